// File: rtl/mold_hdr_parser_if.sv
// Stream and result bundle for mold_hdr_parser: UDP payload beats in, header fields and payload beats out.
// dbg_state mirrors the parser FSM (0 IDLE, 1 HDR, 2 PAY) for observation only.
interface mold_hdr_parser_if #(
    parameter int DATA_W = 64
);
    // No backpressure: every valid_i beat is consumed in its cycle; start_i/last_i mean nothing without valid_i.
    logic              valid_i;
    logic              start_i;
    logic              last_i;
    logic [DATA_W-1:0] data_i;

    logic              hdr_v_o;
    logic [79:0]       sid_o;
    logic [63:0]       seq_num_o;
    logic [15:0]       msg_cnt_o;
    logic              hb_o;
    logic              eos_o;
    logic              gap_o;
    logic              trunc_o;
    logic              pay_v_o;
    logic              pay_last_o;
    logic [DATA_W-1:0] pay_data_o;
    logic [1:0]        dbg_state;

    modport master (
        output valid_i, start_i, last_i, data_i,
        input  hdr_v_o, sid_o, seq_num_o, msg_cnt_o, hb_o, eos_o, gap_o,
        input  trunc_o, pay_v_o, pay_last_o, pay_data_o, dbg_state
    );

    modport slave (
        input  valid_i, start_i, last_i, data_i,
        output hdr_v_o, sid_o, seq_num_o, msg_cnt_o, hb_o, eos_o, gap_o,
        output trunc_o, pay_v_o, pay_last_o, pay_data_o, dbg_state
    );
endinterface

// File: rtl/mold_hdr_parser.sv
// MoldUDP64 header parser: assembles the 20-byte header, flags heartbeat/end-of-session, forwards payload.
// Optional sequence-gap tracking is built when MOLD_SEQ_CHECK_EN is defined; otherwise gap_o is 0.
module mold_hdr_parser #(
    parameter int DATA_W = 64
) (
    input logic             clk,
    input logic             rst,
    mold_hdr_parser_if.slave bus
);
    localparam int HDR_BEATS = (160 + DATA_W - 1) / DATA_W;
    localparam int SR_W      = (HDR_BEATS - 1) * DATA_W;
    localparam int HDR_PAD   = HDR_BEATS * DATA_W - 160;
    localparam int TAIL_HDR  = 160 - SR_W;
    localparam logic [2:0] LAST_HDR = 3'(HDR_BEATS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        beat_cnt;
    logic [SR_W-1:0]   hdr_sr;
    logic [159:0]      hdr_bytes;
    logic [DATA_W-1:0] tail_data;
    logic [DATA_W-1:0] fwd_data;
    logic              start_beat;
    logic              hdr_done;
    logic              trunc_now;
    logic              fwd_now;
    logic              fwd_last;

    logic              hdr_v_q;
    logic [79:0]       sid_q;
    logic [63:0]       seq_q;
    logic [15:0]       cnt_q;
    logic              hb_q;
    logic              eos_q;
    logic              trunc_q;
    logic              pay_v_q;
    logic              pay_last_q;
    logic [DATA_W-1:0] pay_data_q;

    assign start_beat = bus.valid_i & bus.start_i;
    assign hdr_bytes  = {hdr_sr, bus.data_i[DATA_W-1 -: TAIL_HDR]};

    // Bytes past the header in the completing beat move to the MSBs; the low part is passed through as-is.
    if (HDR_PAD != 0) begin : g_tail
        assign tail_data = {bus.data_i[HDR_PAD-1:0], bus.data_i[DATA_W-HDR_PAD-1:0]};
    end else begin : g_no_tail
        assign tail_data = bus.data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A start beat always wins: it abandons whatever packet was in flight.
    always_comb begin
        state_nxt = state;
        if (start_beat) begin
            state_nxt = bus.last_i ? IDLE : HDR;
        end else if (bus.valid_i) begin
            case (state)
                HDR: begin
                    if (beat_cnt == LAST_HDR) state_nxt = bus.last_i ? IDLE : PAY;
                    else if (bus.last_i)      state_nxt = IDLE;
                end
                PAY:     if (bus.last_i) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        hdr_done  = 1'b0;
        trunc_now = 1'b0;
        fwd_now   = 1'b0;
        fwd_last  = 1'b0;
        fwd_data  = bus.data_i;
        if (start_beat) begin
            trunc_now = bus.last_i;
        end else if (bus.valid_i) begin
            case (state)
                HDR: begin
                    if (beat_cnt == LAST_HDR) begin
                        hdr_done = 1'b1;
                        fwd_now  = (HDR_PAD != 0);
                        fwd_last = bus.last_i;
                        fwd_data = tail_data;
                    end else begin
                        trunc_now = bus.last_i;
                    end
                end
                PAY: begin
                    fwd_now  = 1'b1;
                    fwd_last = bus.last_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= 3'd0;
            hdr_sr     <= '0;
            hdr_v_q    <= 1'b0;
            sid_q      <= '0;
            seq_q      <= '0;
            cnt_q      <= '0;
            hb_q       <= 1'b0;
            eos_q      <= 1'b0;
            trunc_q    <= 1'b0;
            pay_v_q    <= 1'b0;
            pay_last_q <= 1'b0;
            pay_data_q <= '0;
        end else begin
            if (start_beat)
                beat_cnt <= bus.last_i ? 3'd0 : 3'd1;
            else if (state == HDR && bus.valid_i)
                beat_cnt <= (hdr_done || bus.last_i) ? 3'd0 : beat_cnt + 3'd1;
            if (start_beat || (state == HDR && bus.valid_i))
                hdr_sr <= {hdr_sr[SR_W-DATA_W-1:0], bus.data_i};
            hdr_v_q    <= hdr_done;
            trunc_q    <= trunc_now;
            pay_v_q    <= fwd_now;
            pay_last_q <= fwd_now & fwd_last;
            if (fwd_now) pay_data_q <= fwd_data;
            if (hdr_done) begin
                sid_q <= hdr_bytes[159:80];
                seq_q <= hdr_bytes[79:16];
                cnt_q <= hdr_bytes[15:0];
                hb_q  <= (hdr_bytes[15:0] == 16'h0000);
                eos_q <= (hdr_bytes[15:0] == 16'hFFFF);
            end
        end
    end

`ifdef MOLD_SEQ_CHECK_EN
    logic [79:0] exp_sid;
    logic [63:0] exp_seq;
    logic        exp_v;
    logic        gap_q;

    // A new session id resyncs silently; an end-of-session packet does not advance the expectation.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_sid <= '0;
            exp_seq <= '0;
            exp_v   <= 1'b0;
            gap_q   <= 1'b0;
        end else if (hdr_done) begin
            gap_q   <= exp_v && (hdr_bytes[159:80] == exp_sid) && (hdr_bytes[79:16] != exp_seq);
            exp_sid <= hdr_bytes[159:80];
            exp_v   <= 1'b1;
            if (hdr_bytes[15:0] != 16'hFFFF)
                exp_seq <= hdr_bytes[79:16] + {48'd0, hdr_bytes[15:0]};
        end
    end

    assign bus.gap_o = gap_q;
`else
    assign bus.gap_o = 1'b0;
`endif

    assign bus.hdr_v_o    = hdr_v_q;
    assign bus.sid_o      = sid_q;
    assign bus.seq_num_o  = seq_q;
    assign bus.msg_cnt_o  = cnt_q;
    assign bus.hb_o       = hb_q;
    assign bus.eos_o      = eos_q;
    assign bus.trunc_o    = trunc_q;
    assign bus.pay_v_o    = pay_v_q;
    assign bus.pay_last_o = pay_last_q;
    assign bus.pay_data_o = pay_data_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_mold_hdr_parser.sv
// Bench for mold_hdr_parser: one 64-bit and one 32-bit instance, exercised one at a time from byte-level packets.
// Expected headers/payload beats are derived from packet bytes; gap expectations follow MOLD_SEQ_CHECK_EN.
module tb_mold_hdr_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mold_hdr_parser_if #(.DATA_W(64)) bus64 ();
    mold_hdr_parser_if #(.DATA_W(32)) bus32 ();

    mold_hdr_parser #(.DATA_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
    mold_hdr_parser #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    localparam logic [79:0] SID_A = 80'h0A0B_0C0D_0E0F_1011_1213;
    localparam logic [79:0] SID_B = 80'h5A5A_0102_0304_0506_0708;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   pkt[$];
    logic [162:0] exp_hdr_q[$];
    logic [162:0] obs_hdr_q[$];
    int           exp_cyc_q[$];
    int           obs_cyc_q[$];
    logic [64:0]  exp_pay_q[$];
    logic [64:0]  obs_pay_q[$];
    int           exp_trunc;
    int           obs_trunc;
    int           hdr_cyc;

    logic         ev[2];
    logic [79:0]  esid[2];
    logic [63:0]  eseq[2];
    logic [79:0]  last_sid[2];

    always @(negedge clk) begin
        if (bus64.hdr_v_o) begin
            obs_hdr_q.push_back({bus64.sid_o, bus64.seq_num_o, bus64.msg_cnt_o, bus64.hb_o, bus64.eos_o, bus64.gap_o});
            obs_cyc_q.push_back(cyc);
        end
        if (bus32.hdr_v_o) begin
            obs_hdr_q.push_back({bus32.sid_o, bus32.seq_num_o, bus32.msg_cnt_o, bus32.hb_o, bus32.eos_o, bus32.gap_o});
            obs_cyc_q.push_back(cyc);
        end
        if (bus64.pay_v_o) obs_pay_q.push_back({bus64.pay_last_o, bus64.pay_data_o});
        if (bus32.pay_v_o) obs_pay_q.push_back({bus32.pay_last_o, 32'h0, bus32.pay_data_o});
        if (bus64.trunc_o) obs_trunc++;
        if (bus32.trunc_o) obs_trunc++;
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gb(input int i);
        return (i < pkt.size()) ? pkt[i] : 8'h00;
    endfunction

    function automatic int bpb_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    // Beat k of the current packet, big-endian, right-aligned in 64 bits.
    function automatic logic [63:0] beat_of(input int d, input int k);
        logic [63:0] v = '0;
        for (int j = 0; j < bpb_of(d); j++) v = {v[55:0], gb(k * bpb_of(d) + j)};
        return v;
    endfunction

    task automatic build_pkt(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt, input int npay);
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(sid[79 - 8*i -: 8]);
        for (int i = 0; i < 8; i++)  pkt.push_back(seq[63 - 8*i -: 8]);
        pkt.push_back(cnt[15:8]);
        pkt.push_back(cnt[7:0]);
        for (int i = 0; i < npay; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drive_beat(input int d, input logic v, input logic s, input logic l, input logic [63:0] data);
        if (d == 0) begin
            bus64.valid_i = v; bus64.start_i = s; bus64.last_i = l; bus64.data_i = data;
        end else begin
            bus32.valid_i = v; bus32.start_i = s; bus32.last_i = l; bus32.data_i = data[31:0];
        end
        @(posedge clk);
        #1;
        bus64.valid_i = 1'b0; bus64.start_i = 1'b0; bus64.last_i = 1'b0;
        bus32.valid_i = 1'b0; bus32.start_i = 1'b0; bus32.last_i = 1'b0;
    endtask

    task automatic send_pkt(input int d, input int max_beats);
        int nb = (pkt.size() + bpb_of(d) - 1) / bpb_of(d);
        int hb = (20 + bpb_of(d) - 1) / bpb_of(d);
        int ns = (max_beats < nb) ? max_beats : nb;
        hdr_cyc = -1;
        for (int k = 0; k < ns; k++) begin
            if (k > 0 && $urandom_range(0, 3) == 0) drive_beat(d, 1'b0, 1'b0, 1'b0, 64'h0);
            drive_beat(d, 1'b1, k == 0, (k == nb - 1), beat_of(d, k));
            if (k == hb - 1) hdr_cyc = cyc;
        end
    endtask

    task automatic expect_pkt(input int d);
        int nb = (pkt.size() + bpb_of(d) - 1) / bpb_of(d);
        int hb = (20 + bpb_of(d) - 1) / bpb_of(d);
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic [63:0] t;
        logic        gap;
        if (nb < hb) begin
            exp_trunc++;
            return;
        end
        for (int i = 0; i < 10; i++) sid = {sid[71:0], gb(i)};
        for (int i = 10; i < 18; i++) seq = {seq[55:0], gb(i)};
        cnt = {gb(18), gb(19)};
        gap = ev[d] && (sid == esid[d]) && (seq != eseq[d]);
        esid[d] = sid;
        ev[d] = 1'b1;
        if (cnt != 16'hFFFF) eseq[d] = seq + 64'(cnt);
        last_sid[d] = sid;
`ifndef MOLD_SEQ_CHECK_EN
        gap = 1'b0;
`endif
        exp_hdr_q.push_back({sid, seq, cnt, cnt == 16'h0000, cnt == 16'hFFFF, gap});
        exp_cyc_q.push_back(hdr_cyc);
        if (hb * bpb_of(d) > 20) begin
            t = beat_of(d, hb - 1);
            exp_pay_q.push_back({nb == hb, t[31:0], t[31:0]});
        end
        for (int k = hb; k < nb; k++) exp_pay_q.push_back({k == nb - 1, beat_of(d, k)});
    endtask

    task automatic check_pkt(input string tag);
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "/hdr_count"}, 192'(obs_hdr_q.size()), 192'(exp_hdr_q.size()));
        n = (obs_hdr_q.size() < exp_hdr_q.size()) ? obs_hdr_q.size() : exp_hdr_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/hdr%0d_fields", tag, i), 192'(obs_hdr_q[i]), 192'(exp_hdr_q[i]));
            chk($sformatf("%s/hdr%0d_cycle", tag, i), 192'(obs_cyc_q[i]), 192'(exp_cyc_q[i]));
        end
        chk({tag, "/pay_count"}, 192'(obs_pay_q.size()), 192'(exp_pay_q.size()));
        n = (obs_pay_q.size() < exp_pay_q.size()) ? obs_pay_q.size() : exp_pay_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s/pay%0d", tag, i), 192'(obs_pay_q[i]), 192'(exp_pay_q[i]));
        chk({tag, "/trunc_count"}, 192'(obs_trunc), 192'(exp_trunc));
        exp_hdr_q.delete(); obs_hdr_q.delete(); exp_cyc_q.delete(); obs_cyc_q.delete();
        exp_pay_q.delete(); obs_pay_q.delete();
        exp_trunc = 0; obs_trunc = 0;
    endtask

    task automatic run(input int d, input string tag, input logic [79:0] sid, input logic [63:0] seq,
                       input logic [15:0] cnt, input int npay);
        build_pkt(sid, seq, cnt, npay);
        send_pkt(d, 1000);
        expect_pkt(d);
        check_pkt($sformatf("%s_w%0d", tag, d == 0 ? 64 : 32));
    endtask

    initial begin
        int r;
        int nb;
        int hb;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        bus64.valid_i = 1'b0; bus64.start_i = 1'b0; bus64.last_i = 1'b0; bus64.data_i = '0;
        bus32.valid_i = 1'b0; bus32.start_i = 1'b0; bus32.last_i = 1'b0; bus32.data_i = '0;
        exp_trunc = 0; obs_trunc = 0;
        for (int d = 0; d < 2; d++) begin ev[d] = 1'b0; esid[d] = '0; eseq[d] = '0; last_sid[d] = '0; end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sid64", 192'(bus64.sid_o), 192'(0));
        chk("rst_seq64", 192'(bus64.seq_num_o), 192'(0));
        chk("rst_cnt64", 192'(bus64.msg_cnt_o), 192'(0));
        chk("rst_flags64", 192'({bus64.hdr_v_o, bus64.hb_o, bus64.eos_o, bus64.gap_o, bus64.trunc_o,
                                 bus64.pay_v_o, bus64.pay_last_o}), 192'(0));
        chk("rst_pay64", 192'(bus64.pay_data_o), 192'(0));
        chk("rst_sid32", 192'(bus32.sid_o), 192'(0));
        chk("rst_seq32", 192'(bus32.seq_num_o), 192'(0));
        chk("rst_cnt32", 192'(bus32.msg_cnt_o), 192'(0));
        chk("rst_flags32", 192'({bus32.hdr_v_o, bus32.hb_o, bus32.eos_o, bus32.gap_o, bus32.trunc_o,
                                 bus32.pay_v_o, bus32.pay_last_o}), 192'(0));
        chk("rst_pay32", 192'(bus32.pay_data_o), 192'(0));

        for (int d = 0; d < 2; d++) begin
            run(d, "basic",    SID_A, 64'd5,  16'd2,    20);
            run(d, "inseq",    SID_A, 64'd7,  16'd1,    8);
            run(d, "gap",      SID_A, 64'd10, 16'd3,    12);
            run(d, "heartbeat", SID_A, 64'd13, 16'h0000, 0);
            run(d, "eos",      SID_A, 64'd13, 16'hFFFF, 4);
            run(d, "after_eos", SID_A, 64'd13, 16'd1,   4);
            run(d, "new_sid",  SID_B, 64'd50, 16'd1,    4);

            // Packet ending on header beat 1.
            build_pkt(SID_A, 64'd99, 16'd4, 0);
            while (pkt.size() > 2 * bpb_of(d)) void'(pkt.pop_back());
            send_pkt(d, 1000);
            expect_pkt(d);
            check_pkt($sformatf("trunc_w%0d", d));
            chk($sformatf("hold_sid_w%0d", d), 192'(d == 0 ? bus64.sid_o : bus32.sid_o), 192'(last_sid[d]));

            // Abandoned header followed by a fresh start.
            build_pkt(SID_B, 64'd77, 16'd3, 8);
            send_pkt(d, 2);
            run(d, "restart", SID_B, 64'd51, 16'd2, 16);

            // Reset during header beat 1, then stray beats without start.
            build_pkt(SID_B, 64'd53, 16'd2, 8);
            drive_beat(d, 1'b1, 1'b1, 1'b0, beat_of(d, 0));
            rst = 1'b1;
            drive_beat(d, 1'b1, 1'b0, 1'b0, beat_of(d, 1));
            rst = 1'b0;
            for (int i = 0; i < 2; i++) begin ev[i] = 1'b0; last_sid[i] = '0; end
            drive_beat(d, 1'b1, 1'b0, 1'b0, {$urandom(), $urandom()});
            drive_beat(d, 1'b1, 1'b0, 1'b1, {$urandom(), $urandom()});
            check_pkt($sformatf("rst_mid_w%0d", d));
            run(d, "post_rst", SID_B, 64'd53, 16'd2, 8);
        end

        for (int it = 0; it < 60; it++) begin
            int d = it % 2;
            hb = (20 + bpb_of(d) - 1) / bpb_of(d);
            r = $urandom_range(0, 9);
            sid = ($urandom_range(0, 3) == 0) ? SID_A : SID_B;
            seq = ($urandom_range(0, 1) == 0) ? eseq[d] : {$urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0:       cnt = 16'h0000;
                1:       cnt = 16'hFFFF;
                default: cnt = 16'($urandom_range(1, 65534));
            endcase
            build_pkt(sid, seq, cnt, $urandom_range(0, 40));
            if (r == 0) begin
                nb = $urandom_range(1, hb - 1);
                while (pkt.size() > nb * bpb_of(d)) void'(pkt.pop_back());
            end
            if (r == 1) send_pkt(d, $urandom_range(1, hb - 1));
            send_pkt(d, 1000);
            expect_pkt(d);
            check_pkt($sformatf("rand%0d_w%0d", it, d == 0 ? 64 : 32));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mold_hdr_parser.md
# mold_hdr_parser

Stateful MoldUDP64 header parser, parametrised in datapath width, that sits between the UDP payload stream and the ITCH message splitter. It tracks the header beat count, assembles the 20-byte header into registered fields, and forwards the payload beats that follow. It also detects heartbeat and end-of-session packets and, optionally, sequence-number gaps against the running session.

## Interface
- `DATA_W`, 64: payload bus width in bits; legal values are 32 and 64.
- `HDR_BEATS`, derived as ceil(160/DATA_W): header beats per packet; 3 when `DATA_W`=64, 5 when `DATA_W`=32.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: input beat valid.
- `start_i` in 1: first beat of a UDP payload; qualified by `valid_i`.
- `last_i` in 1: final beat of a UDP payload; qualified by `valid_i`.
- `data_i` in `DATA_W`: payload bytes, big-endian; byte 0 sits in the MSBs.
- `hdr_v_o` out 1: one-cycle pulse; header fields are valid.
- `sid_o` out 80: session id.
- `seq_num_o` out 64: sequence number.
- `msg_cnt_o` out 16: message count.
- `hb_o` out 1: heartbeat flag (`msg_cnt`==0), valid with `hdr_v_o`.
- `eos_o` out 1: end-of-session flag (`msg_cnt`==16'hFFFF), valid with `hdr_v_o`.
- `gap_o` out 1: sequence gap flag, valid with `hdr_v_o`. Present only under the macro; otherwise tied to 0.
- `trunc_o` out 1: one-cycle pulse; the packet ended inside the header.
- `pay_v_o` out 1: payload beat valid.
- `pay_last_o` out 1: last payload beat.
- `pay_data_o` out `DATA_W`: payload data.

## Operation
- FSM states: IDLE, HDR, PAY.
- IDLE:
  - `valid_i`&`start_i` captures beat 0 and moves to HDR with `beat_cnt`=1.
  - `valid_i` without `start_i` is dropped.
- HDR:
  - Each valid beat is stored into the header shift register and increments `beat_cnt`.
  - The beat with index `HDR_BEATS`-1 completes the header. Only its upper 32 bits are header bytes 16-19; for `DATA_W`=64 its lower 32 bits are the first payload bytes and are forwarded as a payload beat (MSB-aligned, low half unchanged).
  - On completion, go to PAY, or to IDLE if `last_i` is also set.
- PAY: valid beats are forwarded; `last_i` returns the FSM to IDLE.
- `start_i` in any state restarts header capture at beat 0. The partial packet is abandoned with no `trunc_o` and no `pay_last_o`.
- `last_i` in HDR before completion: `trunc_o` pulses, no `hdr_v_o`, FSM returns to IDLE.
- Field mapping (bytes): `sid` is 0-9, `seq_num` is 10-17, `msg_cnt` is 18-19.
- Flags: `hb_o` = (`msg_cnt`==0); `eos_o` = (`msg_cnt`==16'hFFFF).

## Timing
- `hdr_v_o`, fields and flags are registered; they assert the cycle after the completing header beat.
- Field outputs hold their value until the next `hdr_v_o`.
- Payload path has 1-cycle latency: `pay_*_o` is the registered copy of the accepted beat.
- There is no backpressure; the input must not stall mid-beat.
- Reset values:
  - FSM=IDLE, `beat_cnt`=0.
  - All pulses and flags 0.
  - `sid_o`, `seq_num_o`, `msg_cnt_o`, `pay_data_o` all 0.
  - Expected-seq state invalid.
- `rst` asserted mid-packet discards everything. The next beat is ignored unless `start_i` is set.
- `start_i`&`last_i` on the same beat (single-beat packet, shorter than the header): `trunc_o` pulses the next cycle.

## Configuration
- `MOLD_SEQ_CHECK_EN` defined: the block keeps `exp_sid` (80b), `exp_seq` (64b) and `exp_v`. On each `hdr_v_o`:
  - If `exp_v`=0 or `sid`≠`exp_sid`: resync, `gap_o`=0.
  - Otherwise: `gap_o` = (`seq_num`≠`exp_seq`).
  - Then `exp_sid`<=`sid` and `exp_v`<=1.
  - If not `eos`: `exp_seq`<=`seq_num`+`msg_cnt` (64-bit wrap).
  - A heartbeat leaves `exp_seq`=`seq_num`.
- `MOLD_SEQ_CHECK_EN` undefined: no tracking state is built and `gap_o`=0 constantly.

## Test plan
- DATA_W=64: 3 header beats with sid=80'h0A…, seq=5, cnt=2, then 2 payload beats (`last_i` on the second) -> `hdr_v_o` one cycle after beat 2 with exact fields, `hb_o`=`eos_o`=0. Payload forwards 3 beats (the beat-2 low half, then the two payload beats), with `pay_last_o` on the final one.
- DATA_W=32: same packet -> 5 header beats, `hdr_v_o` one cycle after beat 4, fields identical.
- `MOLD_SEQ_CHECK_EN` with seq=5,cnt=2 then seq=7 -> `gap_o`=0. Then seq=10 -> `gap_o`=1 and `exp_seq`=10+cnt.
- `MOLD_SEQ_CHECK_EN`:
  - cnt=0 at seq=9 -> `hb_o`=1, next expected seq stays 9.
  - cnt=16'hFFFF -> `eos_o`=1, expected seq unchanged.
  - A new sid arrives -> `gap_o`=0.
- `last_i` on header beat 1 -> `trunc_o` pulse, no `hdr_v_o`, no `pay_v_o`.
- `rst` during beat 1 of a header, then a beat without `start_i` -> ignored. A later full packet then parses correctly.
